// File: rtl/controller.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXE/MEM/WB.
// In: clk, rst_n, op, funct, zero. Out: write enables, mux selects, state.
module controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [1:0] npc_sel,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t cur;

  logic r_type;
  logic is_addu, is_subu, is_slt, is_jr;
  logic is_addiu, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_r_alu, is_imm, is_exe;

  assign r_type   = (op == 6'b000000);
  assign is_addu  = r_type && (funct == 6'b100001);
  assign is_subu  = r_type && (funct == 6'b100011);
  assign is_slt   = r_type && (funct == 6'b101010);
  assign is_jr    = r_type && (funct == 6'b001000);
  assign is_addiu = (op == 6'b001001);
  assign is_ori   = (op == 6'b001101);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);

  assign is_r_alu = is_addu | is_subu | is_slt;
  assign is_imm   = is_addiu | is_ori | is_lui;
  assign is_exe   = is_r_alu | is_imm | is_lw | is_sw | is_beq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= FETCH;
    end else begin
      unique case (cur)
        FETCH:   cur <= DECODE;
        DECODE:  cur <= is_exe ? EXE : FETCH;
        EXE: begin
          if (is_lw | is_sw)
            cur <= MEM;
          else if (is_r_alu | is_imm)
            cur <= WB;
          else
            cur <= FETCH;
        end
        MEM:     cur <= is_lw ? WB : FETCH;
        WB:      cur <= FETCH;
        default: cur <= FETCH;
      endcase
    end
  end

  logic       pc_c, ir_c, rw_c, mw_c;
  logic [1:0] npc_c, ext_c, rd_c, wd_c;
  logic [2:0] alu_c;
  logic       srcb_c;
  logic       in_dp;

  // EXE, MEM and WB share the datapath setup of the current instruction
  assign in_dp = (cur == EXE) || (cur == MEM) || (cur == WB);

  always_comb begin
    pc_c   = 1'b0;
    ir_c   = 1'b0;
    rw_c   = 1'b0;
    mw_c   = 1'b0;
    npc_c  = 2'b00;
    ext_c  = 2'b00;
    alu_c  = 3'b000;
    srcb_c = 1'b0;
    rd_c   = 2'b00;
    wd_c   = 2'b00;

    if (in_dp) begin
      unique case (1'b1)
        is_subu | is_beq: alu_c = 3'b001;
        is_ori:           alu_c = 3'b010;
        is_slt:           alu_c = 3'b011;
        default:          alu_c = 3'b000;
      endcase
      unique case (1'b1)
        is_addiu | is_lw | is_sw | is_beq: ext_c = 2'b01;
        is_lui:                            ext_c = 2'b10;
        default:                           ext_c = 2'b00;
      endcase
      srcb_c = is_imm | is_lw | is_sw;
    end

    unique case (cur)
      FETCH: begin
        ir_c = 1'b1;
        pc_c = 1'b1;
      end
      DECODE: begin
        unique case (1'b1)
          is_jal: begin
            pc_c  = 1'b1;
            npc_c = 2'b10;
            rw_c  = 1'b1;
            rd_c  = 2'b10;
            wd_c  = 2'b10;
          end
          is_j: begin
            pc_c  = 1'b1;
            npc_c = 2'b10;
          end
          is_jr: begin
            pc_c  = 1'b1;
            npc_c = 2'b11;
          end
          default: ;
        endcase
      end
      EXE: begin
        if (is_beq) begin
          pc_c  = zero;
          npc_c = 2'b01;
        end
      end
      MEM: mw_c = is_sw;
      WB: begin
        rw_c = is_r_alu | is_imm | is_lw;
        rd_c = is_r_alu ? 2'b01 : 2'b00;
        wd_c = is_lw ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  // FETCH drives enables, so reset must mask them directly
  assign pc_wr     = pc_c & rst_n;
  assign ir_wr     = ir_c & rst_n;
  assign reg_wr    = rw_c & rst_n;
  assign mem_wr    = mw_c & rst_n;
  assign npc_sel   = npc_c;
  assign ext_op    = ext_c;
  assign alu_op    = alu_c;
  assign alu_src_b = srcb_c;
  assign reg_dst   = rd_c;
  assign wd_sel    = wd_c;
  assign state     = cur;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: per-cycle state and control checks.
// Covers each instruction class, reset, and reset mid-instruction.
module tb_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_wr, ir_wr, reg_wr, mem_wr;
  logic [1:0] npc_sel, ext_op, reg_dst, wd_sel;
  logic [2:0] alu_op, state;
  logic       alu_src_b;

  int checks = 0;
  int errors = 0;

  controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .pc_wr     (pc_wr),
    .ir_wr     (ir_wr),
    .reg_wr    (reg_wr),
    .mem_wr    (mem_wr),
    .npc_sel   (npc_sel),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // we = {pc_wr, ir_wr, reg_wr, mem_wr}
  task automatic chk(
    input string      tag,
    input logic [2:0] st,
    input logic [3:0] we,
    input logic [1:0] npc,
    input logic [1:0] ext,
    input logic [2:0] alu,
    input logic       sb,
    input logic [1:0] rd,
    input logic [1:0] wd
  );
    logic [18:0] obs, exp;
    obs = {state, pc_wr, ir_wr, reg_wr, mem_wr, npc_sel, ext_op,
           alu_op, alu_src_b, reg_dst, wd_sel};
    exp = {st, we, npc, ext, alu, sb, rd, wd};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(negedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
  endtask

  initial begin
    rst_n = 1'b0;
    zero  = 1'b0;
    set_ins(6'b000000, 6'b100001);
    #2;
    chk("reset", 3'd0, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    chk("reset_clk", 3'd0, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // addu
    chk("addu_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("addu_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("addu_e", 3'd2, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("addu_w", 3'd4, 4'b0010, 2'b00, 2'b00, 3'b000, 1'b0, 2'b01, 2'b00);
    next;
    chk("addu_f2", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // lw
    set_ins(6'b100011, 6'b000000);
    next;
    chk("lw_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("lw_e", 3'd2, 4'b0000, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    chk("lw_m", 3'd3, 4'b0000, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    chk("lw_w", 3'd4, 4'b0010, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b01);
    next;
    chk("lw_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // sw
    set_ins(6'b101011, 6'b000000);
    next;
    chk("sw_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("sw_e", 3'd2, 4'b0000, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    chk("sw_m", 3'd3, 4'b0001, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    chk("sw_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // beq taken
    set_ins(6'b000100, 6'b000000);
    zero = 1'b1;
    next;
    chk("beq1_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("beq1_e", 3'd2, 4'b1000, 2'b01, 2'b01, 3'b001, 1'b0, 2'b00, 2'b00);
    next;
    chk("beq1_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // beq not taken
    zero = 1'b0;
    next;
    chk("beq0_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("beq0_e", 3'd2, 4'b0000, 2'b01, 2'b01, 3'b001, 1'b0, 2'b00, 2'b00);
    next;
    chk("beq0_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // jal
    set_ins(6'b000011, 6'b000000);
    next;
    chk("jal_d", 3'd1, 4'b1010, 2'b10, 2'b00, 3'b000, 1'b0, 2'b10, 2'b10);
    next;
    chk("jal_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // j
    set_ins(6'b000010, 6'b000000);
    next;
    chk("j_d", 3'd1, 4'b1000, 2'b10, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("j_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // jr
    set_ins(6'b000000, 6'b001000);
    next;
    chk("jr_d", 3'd1, 4'b1000, 2'b11, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("jr_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // lui
    set_ins(6'b001111, 6'b000000);
    next;
    next;
    chk("lui_e", 3'd2, 4'b0000, 2'b00, 2'b10, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    chk("lui_w", 3'd4, 4'b0010, 2'b00, 2'b10, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    // ori
    set_ins(6'b001101, 6'b000000);
    next;
    next;
    chk("ori_e", 3'd2, 4'b0000, 2'b00, 2'b00, 3'b010, 1'b1, 2'b00, 2'b00);
    next;
    chk("ori_w", 3'd4, 4'b0010, 2'b00, 2'b00, 3'b010, 1'b1, 2'b00, 2'b00);
    next;
    // subu
    set_ins(6'b000000, 6'b100011);
    next;
    next;
    chk("subu_e", 3'd2, 4'b0000, 2'b00, 2'b00, 3'b001, 1'b0, 2'b00, 2'b00);
    next;
    chk("subu_w", 3'd4, 4'b0010, 2'b00, 2'b00, 3'b001, 1'b0, 2'b01, 2'b00);
    next;
    // slt
    set_ins(6'b000000, 6'b101010);
    next;
    next;
    chk("slt_e", 3'd2, 4'b0000, 2'b00, 2'b00, 3'b011, 1'b0, 2'b00, 2'b00);
    next;
    chk("slt_w", 3'd4, 4'b0010, 2'b00, 2'b00, 3'b011, 1'b0, 2'b01, 2'b00);
    next;
    // addiu
    set_ins(6'b001001, 6'b000000);
    next;
    next;
    chk("addiu_e", 3'd2, 4'b0000, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    chk("addiu_w", 3'd4, 4'b0010, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00);
    next;
    chk("addiu_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // unknown op
    set_ins(6'b111111, 6'b000000);
    next;
    chk("unk_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("unk_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // unknown funct
    set_ins(6'b000000, 6'b111111);
    next;
    chk("unkf_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("unkf_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    // sw aborted by reset in MEM
    set_ins(6'b101011, 6'b000000);
    next;
    next;
    next;
    chk("swr_m", 3'd3, 4'b0001, 2'b00, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("swr_rst", 3'd0, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    chk("swr_hold", 3'd0, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("swr_f", 3'd0, 4'b1100, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);
    next;
    chk("swr_d", 3'd1, 4'b0000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
